uart_rx_tx: RTL and testbench

Full-duplex 8N1 UART transceiver with one receiver and one transmitter sharing a single clock and a single parameter set. It sits between the board UART pins and the application logic. The application gets received bytes as a one-cycle valid strobe plus a held data byte, and sends bytes through an enable/busy handshake. The receiver and transmitter run independently; only clock, reset and parameters are shared.

---
 rtl/uart_rx_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent receiver and transmitter, CPB = CLK_HZ/BIT_RATE clocks per bit; UART_LOOPBACK_EN feeds txd into the receiver.
// Latency: rx_valid 3 + CPB/2 + 9*CPB cycles after the rxd start edge; txd start bit on the edge that accepts uart_tx_en.
// Backpressure: none on RX (single-cycle strobe, data held); TX requests are dropped while uart_tx_busy is high.
module uart_rx_tx #(
    parameter int CLK_HZ       = 25000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_txd,
    input  logic                    uart_tx_en,
    output logic                    uart_tx_busy,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB * STOP_BITS + 1);
    localparam int BW  = $clog2(PAYLOAD_BITS);
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CPB * STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_RECV, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic rx_src;
`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign rx_src     = uart_txd;
`else
    assign rx_src     = uart_rxd;
`endif

    logic [1:0]              rx_sync;
    logic                    rx_prev;
    rx_state_t               rx_state;
    logic [CW-1:0]           rx_cnt;
    logic [BW-1:0]           rx_bit;
    logic [PAYLOAD_BITS-1:0] rx_shift;
    logic                    rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync       <= 2'b11;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            rx_sync       <= {rx_sync[0], rx_src};
            rx_prev       <= rx_s;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            if (!uart_rx_en) begin
                rx_state <= RX_IDLE;
                rx_cnt   <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_s) begin
                            rx_state <= RX_START;
                            rx_cnt   <= '0;
                        end
                    end
                    RX_START: begin
                        // mid-start sample: a line back high means it was only a glitch
                        if (rx_cnt == HALF_LAST) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? RX_IDLE : RX_RECV;
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                    RX_RECV: begin
                        if (rx_cnt == CPB_LAST) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_s, rx_shift[PAYLOAD_BITS-1:1]};
                            if (rx_bit == BIT_LAST) rx_state <= RX_STOP;
                            else rx_bit <= rx_bit + BW'(1);
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt == CPB_LAST) begin
                            rx_cnt   <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_s) begin
                                uart_rx_data  <= rx_shift;
                                uart_rx_valid <= 1'b1;
                            end else if (rx_shift == '0) begin
                                uart_rx_data  <= '0;
                                uart_rx_break <= 1'b1;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    tx_state_t               tx_state;
    logic [CW-1:0]           tx_cnt;
    logic [BW-1:0]           tx_bit;
    logic [PAYLOAD_BITS-1:0] tx_shift;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (uart_tx_en) begin
                        tx_state     <= TX_START;
                        tx_shift     <= uart_tx_data;
                        tx_cnt       <= '0;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CPB_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CPB_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            uart_txd <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + BW'(1);
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    // busy drops on the edge that closes the last stop period
                    if (tx_cnt == STOP_LAST) begin
                        tx_cnt       <= '0;
                        tx_state     <= TX_IDLE;
                        uart_tx_busy <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx at CPB=16; RX results go through an expected-event queue checked as the DUT strobes.
module tb_uart_rx_tx;

    localparam int CLK_HZ   = 153600;
    localparam int BIT_RATE = 9600;
    localparam int RX_LAT   = 3 + 8 + 9 * 16;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] dat;
        int         cyc;
    } rx_ev_t;

    logic       clk          = 1'b0;
    logic       resetn       = 1'b0;
    logic       uart_rxd     = 1'b1;
    logic       uart_rx_en   = 1'b0;
    logic       uart_tx_en   = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_txd;
    logic       uart_tx_busy;

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int n_rx_events = 0;
    rx_ev_t rx_exp[$];
    logic   tx_exp[$];

    uart_rx_tx #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .uart_txd     (uart_txd),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_data (uart_tx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe cycle is one event; a wide or doubled pulse shows up as an unexpected extra event.
    always @(negedge clk) begin
        if (uart_rx_valid || uart_rx_break) begin
            rx_ev_t e;
            logic [1:0] kind;
            kind = {uart_rx_break, uart_rx_valid};
            n_rx_events++;
            n_checks++;
            if (rx_exp.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: kind=%0d data=%h cyc=%0d, required no strobe", kind, uart_rx_data, cyc);
            end else begin
                e = rx_exp.pop_front();
                if (kind !== e.kind || uart_rx_data !== e.dat || cyc !== e.cyc)
                begin
                    n_fail++;
                    $display("FAIL rx_event: kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                             kind, uart_rx_data, cyc, e.kind, e.dat, e.cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame on uart_rxd and queues what the receiver should report for it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
        logic [9:0] fr;
        rx_ev_t e;
        fr = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        e.cyc = cyc + RX_LAT;
        e.dat = d;
        if (abort_at < 0) begin
            if (stop) begin
                e.kind = 2'b01;
                rx_exp.push_back(e);
            end else if (d == 8'h00) begin
                e.kind = 2'b10;
                rx_exp.push_back(e);
            end
        end
        for (int t = 0; t < 160; t++) begin
            uart_rxd = fr[t/16];
            if (t == abort_at) uart_rx_en = 1'b0;
            wait_cyc(1);
        end
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", uart_tx_busy); end
        n_checks++; if (uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", uart_rx_valid); end
        n_checks++; if (uart_rx_break !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b want 0", uart_rx_break); end
        n_checks++; if (uart_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", uart_rx_data); end
        resetn = 1'b1;
`ifndef UART_LOOPBACK_EN
        uart_rx_en = 1'b1;
`endif
        wait_cyc(4);
        n_checks++; if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_tx: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
    endtask

    task automatic test_tx();
        logic [7:0] d;
        logic       b_exp;
        logic       bad;
        d = 8'hA5;
        uart_tx_data = d;
        uart_tx_en   = 1'b1;
        wait_cyc(1);
        uart_tx_en = 1'b0;
        tx_exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp.push_back(d[i]);
        tx_exp.push_back(1'b1);
        n_checks++; if (uart_tx_busy !== 1'b1 || uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL tx_accept: busy=%b txd=%b want 1/0", uart_tx_busy, uart_txd);
        end
        wait_cyc(8);
        for (int b = 0; b < 10; b++) begin
            if (b > 0) begin
                if (b == 3) begin
                    uart_tx_data = 8'hFF;
                    uart_tx_en   = 1'b1;
                    wait_cyc(1);
                    uart_tx_en   = 1'b0;
                    wait_cyc(15);
                end else begin
                    wait_cyc(16);
                end
            end
            b_exp = tx_exp.pop_front();
            n_checks++; if (uart_txd !== b_exp || uart_tx_busy !== 1'b1) begin
                n_fail++; $display("FAIL tx_bit%0d: txd=%b busy=%b want %b/1", b, uart_txd, uart_tx_busy, b_exp);
            end
        end
        wait_cyc(7);
        n_checks++; if (uart_tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_159: got %b want 1", uart_tx_busy); end
        wait_cyc(1);
        n_checks++; if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL tx_busy_160: busy=%b txd=%b want 0/1", uart_tx_busy, uart_txd);
        end
        bad = 1'b0;
        repeat (30) begin
            wait_cyc(1);
            if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL tx_ignored_req: line activity=%b want 0", bad); end
    endtask

    task automatic test_back_to_back();
        uart_tx_data = 8'h3C;
        uart_tx_en   = 1'b1;
        wait_cyc(1);
        n_checks++; if (uart_tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first: busy=%b want 1", uart_tx_busy); end
        wait_cyc(159);
        n_checks++; if (uart_tx_busy !== 1'b1 || uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stop: busy=%b txd=%b want 1/1", uart_tx_busy, uart_txd);
        end
        wait_cyc(1);
        n_checks++; if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap: busy=%b txd=%b want 0/1", uart_tx_busy, uart_txd);
        end
        wait_cyc(1);
        uart_tx_en = 1'b0;
        n_checks++; if (uart_tx_busy !== 1'b1 || uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: busy=%b txd=%b want 1/0", uart_tx_busy, uart_txd);
        end
        wait_cyc(170);
        n_checks++; if (uart_tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: busy=%b want 0", uart_tx_busy); end
    endtask

    task automatic test_rx_valid();
        send_frame(8'h31, 1'b1, -1);
        wait_cyc(20);
        n_checks++; if (rx_exp.size() !== 0) begin n_fail++; $display("FAIL rx_valid_missing: pending=%0d want 0", rx_exp.size()); end
        n_checks++; if (uart_rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_valid_data: got %h want 31", uart_rx_data); end
        wait_cyc(50);
        n_checks++; if (uart_rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_data_hold: got %h want 31", uart_rx_data); end
    endtask

    task automatic test_rx_glitch();
        int ev0;
        ev0 = n_rx_events;
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        wait_cyc(4);
        uart_rxd = 1'b1;
        wait_cyc(200);
        n_checks++; if (n_rx_events !== ev0) begin n_fail++; $display("FAIL rx_glitch_events: got %0d want %0d", n_rx_events, ev0); end
        n_checks++; if (uart_rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_glitch_data: got %h want 31", uart_rx_data); end
    endtask

    task automatic test_rx_frame_err();
        int ev0;
        ev0 = n_rx_events;
        send_frame(8'h55, 1'b0, -1);
        wait_cyc(20);
        n_checks++; if (n_rx_events !== ev0) begin n_fail++; $display("FAIL rx_ferr_events: got %0d want %0d", n_rx_events, ev0); end
        n_checks++; if (uart_rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_ferr_data: got %h want 31", uart_rx_data); end
    endtask

    task automatic test_rx_break();
        send_frame(8'h00, 1'b0, -1);
        wait_cyc(20);
        n_checks++; if (rx_exp.size() !== 0) begin n_fail++; $display("FAIL rx_break_missing: pending=%0d want 0", rx_exp.size()); end
        n_checks++; if (uart_rx_data !== 8'h00) begin n_fail++; $display("FAIL rx_break_data: got %h want 00", uart_rx_data); end
    endtask

    task automatic test_rx_enable();
        int ev0;
        ev0 = n_rx_events;
        send_frame(8'h12, 1'b1, 60);
        wait_cyc(20);
        n_checks++; if (n_rx_events !== ev0) begin n_fail++; $display("FAIL rx_abort_events: got %0d want %0d", n_rx_events, ev0); end
        send_frame(8'h7E, 1'b1, -1);
        wait_cyc(20);
        n_checks++; if (rx_exp.size() !== 0) begin n_fail++; $display("FAIL rx_after_abort_missing: pending=%0d want 0", rx_exp.size()); end
        n_checks++; if (uart_rx_data !== 8'h7E) begin n_fail++; $display("FAIL rx_after_abort_data: got %h want 7e", uart_rx_data); end
    endtask

    task automatic test_loopback();
        rx_ev_t e;
        uart_rxd   = 1'b0;
        uart_rx_en = 1'b1;
        wait_cyc(3);
        uart_tx_data = 8'h3C;
        uart_tx_en   = 1'b1;
        wait_cyc(1);
        uart_tx_en = 1'b0;
        e.kind = 2'b01;
        e.dat  = 8'h3C;
        e.cyc  = cyc + RX_LAT;
        rx_exp.push_back(e);
        wait_cyc(200);
        n_checks++; if (rx_exp.size() !== 0) begin n_fail++; $display("FAIL loopback_missing: pending=%0d want 0", rx_exp.size()); end
        n_checks++; if (uart_rx_data !== 8'h3C) begin n_fail++; $display("FAIL loopback_data: got %h want 3c", uart_rx_data); end
    endtask

    task automatic test_async_reset();
        uart_tx_data = 8'h00;
        uart_tx_en   = 1'b1;
        wait_cyc(1);
        uart_tx_en = 1'b0;
        wait_cyc(30);
        n_checks++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL areset_pre: txd=%b want 0", uart_txd); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        wait_cyc(3);
        n_checks++; if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL areset_release: txd=%b busy=%b want 1/0", uart_txd, uart_tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`else
        test_rx_valid();
        test_rx_glitch();
        test_rx_frame_err();
        test_rx_break();
        test_rx_enable();
`endif
        test_async_reset();
        wait_cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
